muldiv_hilo_unit: RTL and testbench

//   Iterative multiply/divide engine with private HI/LO registers for the EX stage.

---
 rtl/muldiv_hilo_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_hilo_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit
//   Iterative multiply / divide engine for the EX stage with its own HI/LO
//   registers. Handles MULT/MULTU, DIV/DIVU, MADD(U)/MSUB(U) accumulation into
//   {HI,LO}, and MTHI/MTLO writes. EX pulses start for one cycle and stalls
//   while busy is high; done pulses in the cycle the new HI/LO become visible.
//   WIDTH must be even and >= 8; MUL_STEP must divide WIDTH.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start, op     request strobe and opcode (sampled only when idle)
//   rs, rt        operand A / operand B, captured at the start edge
//   flush         abort the in-flight op, HI/LO untouched; beats start
//   busy, done    handshake: op in progress / one-cycle completion pulse
//   hi_out,lo_out HI and LO registers
module muldiv_hilo_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_MULT  = 4'd1, OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3, OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MADD  = 4'd5, OP_MADDU = 4'd6;
    localparam logic [3:0] OP_MSUB  = 4'd7, OP_MSUBU = 4'd8;
    localparam logic [3:0] OP_MTHI  = 4'd9, OP_MTLO  = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    state_t state, state_d;

    logic [3:0]         op_r;
    logic               neg_res;   // negate product / quotient in FIX
    logic               neg_rem;   // negate remainder (dividend was negative)
    logic [CW-1:0]      cnt;
    // MUL: acc = product so far, mcand = shifted multiplicand, mplier = bits left.
    // DIV: acc = {remainder, dividend/quotient shift register}, mplier = divisor.
    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;

    // ---------------- request decode / operand conditioning ----------------
    logic             op_mul, op_div, accept, rs_neg, rt_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign op_mul = op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
    assign op_div = op inside {OP_DIV, OP_DIVU};
    assign accept = start && !flush && (state == S_IDLE);
    // Odd opcodes in 1..8 are the signed variants.
    assign rs_neg = op[0] && rs[WIDTH-1];
    assign rt_neg = op[0] && rt[WIDTH-1];
    assign a_mag  = rs_neg ? -rs : rs;
    assign b_mag  = rt_neg ? -rt : rt;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept && op_mul)      state_d = S_MUL;
                else if (accept && op_div) state_d = S_DIV;
            end
            S_MUL:   if (cnt == MUL_LAST) state_d = S_FIX;
            S_DIV:   if (cnt == DIV_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    assign busy = (state != S_IDLE);

    // ---------------- multiply step: MUL_STEP shift-adds per cycle ----------------
    logic [2*WIDTH-1:0] mul_next;
    always_comb begin
        mul_next = acc;
        for (int i = 0; i < MUL_STEP; i++)
            if (mplier[i]) mul_next = mul_next + (mcand << i);
    end

    // ---------------- divide step: one restoring radix-2 iteration ----------------
    logic [WIDTH:0]     rem_sh, diff;
    logic [2*WIDTH-1:0] div_next;
    always_comb begin
        rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff   = rem_sh - {1'b0, mplier};
        // diff[WIDTH] set means the trial subtraction went negative: restore.
        if (diff[WIDTH]) div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else             div_next = {diff[WIDTH-1:0],   acc[WIDTH-2:0], 1'b1};
    end

    // ---------------- FIX: sign correction and accumulation ----------------
    logic [WIDTH-1:0]   quo, rem;
    logic [2*WIDTH-1:0] prod, hilo, fix_res;
    always_comb begin
        quo  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        prod = neg_res ? -acc : acc;
        hilo = {hi_out, lo_out};
        case (op_r)
            OP_MADD, OP_MADDU: fix_res = hilo + prod;
            OP_MSUB, OP_MSUBU: fix_res = hilo - prod;
            OP_DIV,  OP_DIVU:  fix_res = {rem, quo};
            default:           fix_res = prod;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            hi_out  <= '0;
            lo_out  <= '0;
            op_r    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    if (op == OP_MTHI) hi_out <= rs;
                    if (op == OP_MTLO) lo_out <= rs;
                    if (op_mul || op_div) begin
                        op_r    <= op;
                        // Divide by zero keeps the quotient positive so LO reads
                        // all ones regardless of the dividend's sign.
                        neg_res <= (rs_neg ^ rt_neg) && !(op_div && rt == '0);
                        neg_rem <= rs_neg;
                        cnt     <= '0;
                        mplier  <= b_mag;
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        acc     <= op_div ? {{WIDTH{1'b0}}, a_mag} : '0;
                    end
                end
                S_MUL: begin
                    acc    <= mul_next;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    cnt    <= cnt + CW'(1);
                end
                S_DIV: begin
                    acc <= div_next;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: if (!flush) begin
                    hi_out <= fix_res[2*WIDTH-1:WIDTH];
                    lo_out <= fix_res[WIDTH-1:0];
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
module tb_muldiv_hilo_unit;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        busy, done;
    logic [31:0] hi_out, lo_out;

    muldiv_hilo_unit #(.WIDTH(32), .MUL_STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .rs(rs), .rt(rt),
        .flush(flush), .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    logic [63:0] sb_q[$];
    logic [63:0] m_hl = '0;   // model copy of {HI,LO}

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour using native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o[0]) p = 64'(sa * sb);
        else      p = {32'h0, a} * {32'h0, b};
        case (o)
            4'd1, 4'd2: return p;
            4'd5, 4'd6: return hl + p;
            4'd7, 4'd8: return hl - p;
            4'd3:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
            4'd4:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            4'd9:  return {a, hl[31:0]};
            4'd10: return {hl[63:32], a};
            default: return hl;
        endcase
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) chk("spurious_done", 64'(done), 64'd0);
            else                  chk("sb_hilo", {hi_out, lo_out}, sb_q.pop_front());
        end
    end

    // Issue one op at posedge+1, return at posedge+1 of the done cycle
    // (or right after the start edge for ops that do not go busy).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int          lat, exp_lat;
        bit          long_op;
        e       = model(o, a, b, m_hl);
        long_op = (o >= 4'd1 && o <= 4'd8);
        exp_lat = (o == 4'd3 || o == 4'd4) ? 33 : 9;
        if (long_op) sb_q.push_back(e);
        m_hl  = e;
        start = 1'b1; op = o; rs = a; rt = b;
        @(posedge clk); #1;
        // Scramble operands: results must depend only on the start-edge values.
        start = 1'b0; rs = $urandom; rt = $urandom;
        if (!long_op) begin
            chk("nobusy_op", 64'(busy), 64'd0);
            chk("direct_hilo", {hi_out, lo_out}, e);
            return;
        end
        chk("busy_after_start", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("busy_in_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] prior;
        logic [3:0]  ro;
        logic [31:0] rb;
        int          lat;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; rs = '0; rt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases with literal expectations.
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(4'd4, 32'd7, 32'd0);
        chk("divu_zero", {hi_out, lo_out}, 64'h0000_0007_FFFF_FFFF);
        run_op(4'd3, 32'hFFFF_FFFB, 32'd0);
        chk("div_zero_neg", {hi_out, lo_out}, 64'hFFFF_FFFB_FFFF_FFFF);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
        run_op(4'd9, 32'h10, 32'd0);
        run_op(4'd10, 32'h20, 32'd0);
        run_op(4'd5, 32'd3, 32'd4);
        chk("madd", {hi_out, lo_out}, 64'h0000_0010_0000_002C);
        run_op(4'd8, 32'h2D, 32'd1);
        chk("msubu", {hi_out, lo_out}, 64'h0000_000F_FFFF_FFFF);

        // Start while busy (an MTHI) must be ignored.
        sb_q.push_back(model(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, m_hl));
        m_hl  = model(4'd2, 32'h1234_5678, 32'h9ABC_DEF0, m_hl);
        start = 1'b1; op = 4'd2; rs = 32'h1234_5678; rt = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 1'b1; op = 4'd9; rs = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("b2b_latency", 64'(lat), 64'd9);
        chk("b2b_hilo", {hi_out, lo_out}, m_hl);

        // Flush mid-DIV: no done, HI/LO untouched.
        prior = m_hl;
        start = 1'b1; op = 4'd3; rs = 32'd100; rt = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hilo", {hi_out, lo_out}, prior);

        // Same-cycle flush+start: neither a MUL nor an MTHI may take effect.
        start = 1'b1; flush = 1'b1; op = 4'd1; rs = 32'd5; rt = 32'd6;
        @(posedge clk); #1;
        chk("flush_start_busy", 64'(busy), 64'd0);
        op = 4'd9;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("flush_start_hilo", {hi_out, lo_out}, prior);

        // Randomised mix, including zero divisors and NOP codes.
        for (int k = 0; k < 16; k++) begin
            ro = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            run_op(ro, $urandom, rb);
        end

        // Asynchronous reset in the middle of a MUL.
        start = 1'b1; op = 4'd6; rs = 32'hFFFF_0000; rt = 32'h0000_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_hilo", {hi_out, lo_out}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; m_hl = '0;
        run_op(4'd1, 32'd7, 32'hFFFF_FFFF);
        chk("post_rst_mult", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFF9);

        repeat (2) @(posedge clk);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
